// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and types for the 8-to-1 nibble selector
package mux_pkg;
  localparam int MUX_WIDTH = 4;
  localparam int MUX_NSEL  = 3;
  localparam int MUX_NIN   = 8;

  typedef logic [MUX_WIDTH-1:0] nibble_t;
endpackage

// File: rtl/mux_8to1_if.sv
// rtl/mux_8to1_if.sv - data/select bus for the 8-to-1 nibble selector
interface mux_8to1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int NSEL  = MUX_NSEL
) ();
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [WIDTH-1:0] in5;
  logic [WIDTH-1:0] in6;
  logic [WIDTH-1:0] in7;
  logic [WIDTH-1:0] in8;
  logic [NSEL-1:0]  sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;

  modport master (
    output in1, in2, in3, in4, in5, in6, in7, in8, sel,
    input  out, out_q
  );

  modport slave (
    input  in1, in2, in3, in4, in5, in6, in7, in8, sel,
    output out, out_q
  );
endinterface

// File: rtl/mux_sel_decoder.sv
// rtl/mux_sel_decoder.sv - one-hot select decoder built from AND/NOT gates
module mux_sel_decoder
  import mux_pkg::*;
#(
  parameter int NSEL = MUX_NSEL
) (
  input  logic [NSEL-1:0]      sel,
  output logic [(1<<NSEL)-1:0] d
);
  logic [NSEL-1:0] nsel;

  assign nsel = ~sel;

  // Each output ANDs one literal per select bit: true or inverted per code k.
  for (genvar k = 0; k < (1 << NSEL); k++) begin : g_code
    logic [NSEL-1:0] lit;
    for (genvar i = 0; i < NSEL; i++) begin : g_lit
      if (((k >> i) & 1) == 1) begin : g_true
        assign lit[i] = sel[i];
      end else begin : g_inv
        assign lit[i] = nsel[i];
      end
    end
    assign d[k] = &lit;
  end
endmodule

// File: rtl/mux_8to1.sv
// rtl/mux_8to1.sv - 8-to-1 nibble selector: AND-OR tree plus registered copy
module mux_8to1
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH,
  parameter int NSEL  = MUX_NSEL
) (
  input  logic       clk,
  input  logic       rst,
  mux_8to1_if.slave  bus
);
  localparam int NIN = 1 << NSEL;

  logic [WIDTH-1:0] ins [NIN];
  logic [NIN-1:0]   d;
  logic [WIDTH-1:0] out_c;

  assign ins[0] = bus.in1;
  assign ins[1] = bus.in2;
  assign ins[2] = bus.in3;
  assign ins[3] = bus.in4;
  assign ins[4] = bus.in5;
  assign ins[5] = bus.in6;
  assign ins[6] = bus.in7;
  assign ins[7] = bus.in8;

  mux_sel_decoder #(.NSEL(NSEL)) u_dec (
    .sel (bus.sel),
    .d   (d)
  );

  // No priority: the decoder guarantees a single live term per bit.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NIN-1:0] terms;
    for (genvar k = 0; k < NIN; k++) begin : g_term
      assign terms[k] = d[k] & ins[k][b];
    end
    assign out_c[b] = |terms;
  end

  assign bus.out = out_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_q <= '0;
    end else begin
      bus.out_q <= out_c;
    end
  end
endmodule

// File: tb/tb_mux_8to1.sv
// tb/tb_mux_8to1.sv - directed self-checking bench for mux_8to1
module tb_mux_8to1;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  nibble_t vals [8];
  nibble_t q_seq [9];

  mux_8to1_if bus ();

  mux_8to1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input nibble_t obs, input nibble_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_all(input nibble_t v);
    bus.in1 = v; bus.in2 = v; bus.in3 = v; bus.in4 = v;
    bus.in5 = v; bus.in6 = v; bus.in7 = v; bus.in8 = v;
  endtask

  task automatic load_vals();
    bus.in1 = vals[0]; bus.in2 = vals[1]; bus.in3 = vals[2]; bus.in4 = vals[3];
    bus.in5 = vals[4]; bus.in6 = vals[5]; bus.in7 = vals[6]; bus.in8 = vals[7];
  endtask

  initial begin
    vals  = '{4'd12, 4'd4, 4'd7, 4'd11, 4'd15, 4'd10, 4'd8, 4'd1};
    q_seq = '{4'd0, 4'd12, 4'd4, 4'd7, 4'd11, 4'd15, 4'd10, 4'd8, 4'd1};

    load_vals();
    bus.sel = 3'd0;
    #1;
    check("reset_out_q", bus.out_q, 4'd0);
    check("reset_out_unaffected", bus.out, 4'd12);

    // Combinational sweep while still in reset
    for (int i = 0; i < 8; i++) begin
      bus.sel = 3'(i);
      #1;
      check($sformatf("comb_sel%0d", i), bus.out, vals[i]);
      check($sformatf("hold_rst_out_q%0d", i), bus.out_q, 4'd0);
      #9;
    end

    bus.sel = 3'd3;
    bus.in4 = 4'd6;
    #1;
    check("sel3_in4_change", bus.out, 4'd6);
    bus.in1 = 4'd3; bus.in3 = 4'd9; bus.in5 = 4'd2; bus.in8 = 4'd14;
    #1;
    check("sel3_other_inputs", bus.out, 4'd6);
    load_vals();

    // Async reset mid-cycle
    bus.sel = 3'd4;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("load_after_deassert", bus.out_q, 4'd15);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_no_edge", bus.out_q, 4'd0);
    check("async_reset_out", bus.out, 4'd15);
    #1;
    rst = 1'b0;
    #1;
    check("no_load_before_edge", bus.out_q, 4'd0);
    @(posedge clk);
    #1;
    check("reload_after_reset", bus.out_q, 4'd15);

    // Clocked run: out_q trails out by one cycle
    @(negedge clk);
    rst = 1'b1;
    bus.sel = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    check("clk_run_q0", bus.out_q, q_seq[0]);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("clk_run_q%0d", i), bus.out_q, q_seq[i]);
      bus.sel = 3'(i);
      #1;
      check($sformatf("clk_run_out%0d", i), bus.out, vals[i]);
    end
    @(negedge clk);
    check("clk_run_q8", bus.out_q, q_seq[8]);

    load_all(4'hF);
    for (int i = 0; i < 8; i++) begin
      bus.sel = 3'(i);
      #1;
      check($sformatf("all_ones_sel%0d", i), bus.out, 4'hF);
    end
    load_all(4'h0);
    for (int i = 0; i < 8; i += 7) begin
      bus.sel = 3'(i);
      #1;
      check($sformatf("all_zero_sel%0d", i), bus.out, 4'h0);
    end

    // Reset raised in the same timestep as a rising edge
    load_all(4'hF);
    bus.sel = 3'd2;
    @(negedge clk);
    @(negedge clk);
    check("pre_race_out_q", bus.out_q, 4'hF);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("race_out_q", bus.out_q, 4'd0);
    check("race_out", bus.out, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
